// File: rtl/bcd2binary_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Define BCD2BIN_DIGIT_CHECK_EN to flag digits >9 (bcd_err=1, bin_out forced to 0).
module bcd2binary_seq #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    bcd_err
);

    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [4*NUM_DIGITS-1:0] sreg;
    logic [BIN_W-1:0]        acc;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              digit;
    logic [BIN_W-1:0]        acc_nxt;
    logic [BIN_W-1:0]        result;
    logic                    result_err;
    logic                    capture;
    logic                    load;
    logic                    release_out;

    // acc*10 + digit, naturally wrapping mod 2^BIN_W
    always_comb begin
        digit   = sreg[4*NUM_DIGITS-1 -: 4];
        acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(digit);
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_flag;
    logic err_nxt;

    always_comb begin
        err_nxt    = err_flag | (digit > 4'd9);
        result_err = err_nxt;
        result     = err_nxt ? '0 : acc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
        end else if (capture) begin
            err_flag <= 1'b0;
        end else if (state == CONV) begin
            err_flag <= err_nxt;
        end
    end
`else
    always_comb begin
        result_err = 1'b0;
        result     = acc_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        capture     = 1'b0;
        load        = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == LAST_CNT) begin
                    load      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            bin_out   <= '0;
            bcd_err   <= 1'b0;
        end else begin
            if (capture) begin
                sreg <= bcd_in;
                acc  <= '0;
                cnt  <= '0;
            end else if (state == CONV) begin
                sreg <= sreg << 4;
                acc  <= acc_nxt;
                cnt  <= cnt + CNT_W'(1);
            end
            if (load) begin
                bin_out   <= result;
                bcd_err   <= result_err;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Directed bench for bcd2binary_seq: vector table, handshake corner cases, full valid-BCD sweep.
// Expected values follow BCD2BIN_DIGIT_CHECK_EN when it is defined.
module tb_bcd2binary_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] bcd_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [13:0] bin_out;
    logic        bcd_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [13:0] out_q[$];
    logic        err_q[$];

    bcd2binary_seq #(.NUM_DIGITS(4), .BIN_W(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .bcd_err   (bcd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // output handshakes sampled mid-cycle, committed at the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            out_q.push_back(bin_out);
            err_q.push_back(bcd_err);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int bcd_value(input logic [15:0] b);
        bcd_value = b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
    endfunction

    // one transaction: offer bcd, measure latency, hold out_ready low for 'hold' extra cycles
    task automatic run_txn(input string name, input logic [15:0] bcd, input int exp_bin,
                           input int exp_err, input int hold);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        bcd_in   = bcd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        chk({name, "_in_ready_wait"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        bcd_in   = 16'hFFFF;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        chk({name, "_latency"}, n, 4);
        chk({name, "_bin"}, int'(bin_out), exp_bin);
        chk({name, "_err"}, int'(bcd_err), exp_err);
        repeat (hold) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, int'(out_valid), 1);
            chk({name, "_hold_bin"}, int'(bin_out), exp_bin);
            chk({name, "_hold_ready"}, int'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_valid_drop"}, int'(out_valid), 0);
        chk({name, "_ready_back"}, int'(in_ready), 1);
    endtask

    typedef struct {
        string       name;
        logic [15:0] bcd;
        int          exp_bin;
        int          exp_err;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   n;
        int   qsz;
        int   bad_val;
        int   bad_err;
        int   bad_rt;

`ifdef BCD2BIN_DIGIT_CHECK_EN
        vecs[0] = '{"v12a4", 16'h12A4, 0, 1};
        vecs[1] = '{"vffff", 16'hFFFF, 0, 1};
        vecs[2] = '{"va000", 16'hA000, 0, 1};
`else
        vecs[0] = '{"v12a4", 16'h12A4, 1304, 0};
        vecs[1] = '{"vffff", 16'hFFFF, 281, 0};
        vecs[2] = '{"va000", 16'hA000, 10000, 0};
`endif
        vecs[3] = '{"v9999", 16'h9999, 9999, 0};
        vecs[4] = '{"v0009", 16'h0009, 9, 0};
        vecs[5] = '{"v9990", 16'h9990, 9990, 0};
        vecs[6] = '{"v0807", 16'h0807, 807, 0};

        // reset values, including in_ready while held in reset
        #23;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_bin", int'(bin_out), 0);
        chk("rst_err", int'(bcd_err), 0);
        in_valid = 1'b1;
        bcd_in   = 16'h1111;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("rst_no_capture", int'(in_ready), 1);

        foreach (vecs[i]) run_txn(vecs[i].name, vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, 0);

        // out_ready held low for 5 cycles after out_valid
        run_txn("stall1234", 16'h1234, 1234, 0, 5);

        // back-to-back with in_valid held and out_ready held
        out_q.delete();
        err_q.delete();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bcd_in    = 16'h0000;
        @(negedge clk);
        chk("b2b_first_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        bcd_in = 16'h0001;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (in_ready) break;
        end
        chk("b2b_capture_gap", n, 6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        qsz = out_q.size();
        chk("b2b_count", qsz, 2);
        if (qsz == 2) begin
            chk("b2b_res0", int'(out_q[0]), 0);
            chk("b2b_res1", int'(out_q[1]), 1);
        end

        // reset asserted mid-conversion abandons the transaction
        out_q.delete();
        @(posedge clk); #1;
        in_valid = 1'b1;
        bcd_in   = 16'h5678;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_bin", int'(bin_out), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_result", out_q.size(), 0);
        chk("midrst_valid_idle", int'(out_valid), 0);
        run_txn("after_rst", 16'h0042, 42, 0, 0);

        // sweep every valid BCD input with the output side always ready
        out_q.delete();
        err_q.delete();
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'b1;
            bcd_in   = to_bcd(i);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 20);
            if (!in_ready) begin
                chk("sweep_ready_timeout", i, -1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("sweep_count", out_q.size(), 10000);
        bad_val = 0;
        bad_err = 0;
        bad_rt  = 0;
        for (int i = 0; i < out_q.size() && i < 10000; i++) begin
            if (int'(out_q[i]) != i) bad_val++;
            if (err_q[i] !== 1'b0) bad_err++;
            if (to_bcd(int'(out_q[i])) !== to_bcd(i) || bcd_value(to_bcd(int'(out_q[i]))) != i) bad_rt++;
        end
        chk("sweep_value_mismatches", bad_val, 0);
        chk("sweep_err_set", bad_err, 0);
        chk("sweep_roundtrip_mismatches", bad_rt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
